// File: rtl/seq_gen.sv
// seq_gen: serial framer emitting marker 1010, bit-stuffed payload, optional tail stuff, idle gap
module seq_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_BITS   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  dout,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, MARK, DATA, STUFF, TAIL, GAP} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            hist_q, hist_d;
  logic                  dout_q, dout_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic                  bit_out, last, hit;
  logic [2:0]            hist_new;
  assign data_ready = state_q == IDLE;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  // hist_q keeps the two older bits; with the bit being emitted it forms the 3-bit history
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    bit_out = 1'b0;
    last    = bit_q == BW'(DATA_WIDTH - 1);
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          sr_d    = data_in;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = MARK;
        end
      end
      MARK: begin
        bit_out = ~cnt_q[0];
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'd3 ? DATA : MARK;
      end
      DATA: begin
        bit_out = sr_q[DATA_WIDTH-1];
        sr_d    = sr_q << 1;
        bit_d   = bit_q + 1'b1;
        cnt_d   = '0;
      end
      STUFF: begin
        bit_out = 1'b1;
        state_d = DATA;
      end
      TAIL: begin
        bit_out = 1'b1;
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'(GAP_BITS - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    hist_new = {hist_q, bit_out};
    hit      = hist_new == 3'b101;
    if (state_q == DATA)
      state_d = hit ? (last ? TAIL : STUFF) : (last ? GAP : DATA);
    hist_d       = (state_q == IDLE || state_q == GAP) ? 2'b00 : hist_new[1:0];
    dout_d       = bit_out;
    busy_d       = state_q != IDLE;
    frame_done_d = (state_q == DATA && last && !hit) || state_q == TAIL;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      hist_q       <= '0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_q        <= bit_d;
      cnt_q        <= cnt_d;
      hist_q       <= hist_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed scoreboard bench for seq_gen with a 1010 detector model on dout
module tb_seq_gen;
  localparam int W = 8;
  localparam int G = 2;
  typedef struct {
    logic d;
    logic b;
    logic f;
    logic r;
    logic first;
  } exp_t;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_ready, dout, busy, frame_done;
  exp_t         q[$];
  int           n_vec = 0, n_err = 0, pend = 0, busy_cnt = 0, fires = 0;
  logic [3:0]   det = 4'b0000;
  always #5 clock = ~clock;
  seq_gen #(.DATA_WIDTH(W), .GAP_BITS(G)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .dout(dout), .busy(busy), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  // expected line activity for one frame, starting with the IDLE->MARK cycle
  function automatic void push_frame(input logic [W-1:0] w);
    logic [2:0] h = 3'b010;
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) q.push_back('{(i % 2 == 0), 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = W - 1; i >= 0; i--) begin
      h = {h[1:0], w[i]};
      q.push_back('{w[i], 1'b1, (i == 0) && (h != 3'b101), 1'b0, 1'b0});
      if (h == 3'b101) begin
        q.push_back('{1'b1, 1'b1, (i == 0), 1'b0, 1'b0});
        h = {h[1:0], 1'b1};
      end
    end
    for (int i = 0; i < G; i++) q.push_back('{1'b0, 1'b1, 1'b0, (i == G - 1), 1'b0});
  endfunction
  task automatic drain;
    exp_t e;
    busy_cnt = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("dout", dout, e.d);
      chk("busy", busy, e.b);
      chk("frame_done", frame_done, e.f);
      chk("data_ready", data_ready, e.r);
      if (busy) busy_cnt++;
      det = {det[2:0], dout};
      if (det == 4'b1010) fires++;
      if (e.first) begin
        pend--;
        if (pend == 0) data_valid = 1'b0;
      end
      if (q.size() > 0) begin
        @(posedge clock);
        #1;
      end
    end
  endtask
  task automatic send(input logic [W-1:0] w, input int len);
    data_in = w;
    data_valid = 1'b1;
    pend = 1;
    fires = 0;
    push_frame(w);
    @(posedge clock);
    #1;
    drain();
    chk($sformatf("len_%02h", w), busy_cnt, len + G);
    chk($sformatf("fires_%02h", w), fires, 1);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_ready", data_ready, 1);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    send(8'h00, 12);
    send(8'hFF, 13);
    send(8'hAA, 16);
    send(8'h05, 13);
    data_in = 8'h05;
    data_valid = 1'b1;
    pend = 2;
    fires = 0;
    push_frame(8'h05);
    push_frame(8'hAA);
    @(posedge clock);
    #1;
    data_in = 8'hAA;
    drain();
    chk("b2b_len", busy_cnt, 13 + 16 + 2 * G);
    chk("b2b_fires", fires, 2);
    data_in = 8'hF0;
    data_valid = 1'b1;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    det = 4'b0000;
    chk("abort_dout", dout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_ready", data_ready, 1);
    send(8'hFF, 13);
    data_in = 8'hFF;
    data_valid = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    data_valid = 1'b0;
    chk("rsths_ready", data_ready, 1);
    @(posedge clock);
    #1;
    chk("rsths_dout", dout, 0);
    chk("rsths_busy", busy, 0);
    chk("rsths_ready2", data_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
